// File: rtl/decode_packet_compactor.sv
// Two-entry FIFO that packs the valid lanes of each decoded bundle down to lane 0
// and presents the head bundle to the instruction buffer straight from registers.
module decode_packet_compactor #(
   parameter int LANES = 8,
   parameter int PKT_W = 2*32 + 3 + 2 + 2 + 16 + 1 + 3*5 + 3 + 8 + 2*32 + 2 + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_i,

   input  logic                 bundleValid_i,
   input  logic [LANES-1:0]     bundleVector_i,
   input  logic [PKT_W-1:0]     bundlePacket0_i,
   input  logic [PKT_W-1:0]     bundlePacket1_i,
   input  logic [PKT_W-1:0]     bundlePacket2_i,
   input  logic [PKT_W-1:0]     bundlePacket3_i,
   input  logic [PKT_W-1:0]     bundlePacket4_i,
   input  logic [PKT_W-1:0]     bundlePacket5_i,
   input  logic [PKT_W-1:0]     bundlePacket6_i,
   input  logic [PKT_W-1:0]     bundlePacket7_i,
   output logic                 bundleReady_o,

   input  logic                 stallFetch_i,
   output logic                 decodeReady_o,
   output logic [LANES-1:0]     decodedVector_o,
   output logic [PKT_W-1:0]     decodedPacket0_o,
   output logic [PKT_W-1:0]     decodedPacket1_o,
   output logic [PKT_W-1:0]     decodedPacket2_o,
   output logic [PKT_W-1:0]     decodedPacket3_o,
   output logic [PKT_W-1:0]     decodedPacket4_o,
   output logic [PKT_W-1:0]     decodedPacket5_o,
   output logic [PKT_W-1:0]     decodedPacket6_o,
   output logic [PKT_W-1:0]     decodedPacket7_o,
   output logic [1:0]           occupancy_o
);

   localparam int IDX_W = $clog2(LANES);

   typedef logic [LANES-1:0][PKT_W-1:0] lane_pkts_t;

   typedef struct packed {
      logic [LANES-1:0] vec;
      lane_pkts_t       pkt;
   } entry_t;

   lane_pkts_t in_pkt;
   entry_t     comp;
   entry_t     head_q, head_d;
   entry_t     tail_q, tail_d;
   logic [1:0] occ_q, occ_d;
   logic [1:0] occ_after_pop;
   logic       push, pop;

   assign in_pkt = {bundlePacket7_i, bundlePacket6_i, bundlePacket5_i, bundlePacket4_i,
                    bundlePacket3_i, bundlePacket2_i, bundlePacket1_i, bundlePacket0_i};

   // Lane j of the packed bundle takes the j-th set bit of the input vector.
   always_comb begin : compact
      logic [IDX_W:0] cnt;
      // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
      comp = '0;
      cnt  = '0;
      for (int i = 0; i < LANES; i++) begin
         if (bundleVector_i[i]) begin
            comp.pkt[cnt[IDX_W-1:0]] = in_pkt[i];
            comp.vec[cnt[IDX_W-1:0]] = 1'b1;
            cnt = cnt + 1'b1;
         end
      end
   end

   assign bundleReady_o = ~occ_q[1];
   assign decodeReady_o = (occ_q != 2'd0);

   assign push = bundleValid_i & bundleReady_o & (|bundleVector_i) & ~flush_i;
   assign pop  = decodeReady_o & ~stallFetch_i & ~flush_i;

   // Head is always entry 0; a pop shifts the tail forward so outputs stay register-driven.
   always_comb begin : next_state
      head_d        = head_q;
      tail_d        = tail_q;
      occ_after_pop = occ_q;
      if (pop) begin
         head_d        = tail_q;
         tail_d        = '0;
         occ_after_pop = occ_q - 2'd1;
      end
      occ_d = occ_after_pop;
      if (push) begin
         if (occ_after_pop == 2'd0) begin
            head_d = comp;
         end else begin
            tail_d = comp;
         end
         occ_d = occ_after_pop + 2'd1;
      end
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end
   end

   // NOTE: packet storage is reset as well, because the head lanes drive the outputs and must read zero in reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign occupancy_o      = occ_q;
   assign decodedVector_o  = head_q.vec;
   assign decodedPacket0_o = head_q.pkt[0];
   assign decodedPacket1_o = head_q.pkt[1];
   assign decodedPacket2_o = head_q.pkt[2];
   assign decodedPacket3_o = head_q.pkt[3];
   assign decodedPacket4_o = head_q.pkt[4];
   assign decodedPacket5_o = head_q.pkt[5];
   assign decodedPacket6_o = head_q.pkt[6];
   assign decodedPacket7_o = head_q.pkt[7];

endmodule

// File: tb/tb_decode_packet_compactor.sv
// Scoreboard bench for decode_packet_compactor: expected bundles are queued on push
// and compared against the presented head every cycle until popped.
module tb_decode_packet_compactor;

   localparam int PKT_W = 2*32 + 3 + 2 + 2 + 16 + 1 + 3*5 + 3 + 8 + 2*32 + 2 + 1;

   typedef logic [7:0][PKT_W-1:0] pkt_arr_t;
   typedef struct packed {
      logic [7:0] vec;
      pkt_arr_t   pkt;
   } bundle_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush_i;
   logic             bundleValid_i;
   logic [7:0]       bundleVector_i;
   pkt_arr_t         in_pkt;
   logic             bundleReady_o;
   logic             stallFetch_i;
   logic             decodeReady_o;
   logic [7:0]       decodedVector_o;
   logic [PKT_W-1:0] dp0, dp1, dp2, dp3, dp4, dp5, dp6, dp7;
   logic [1:0]       occupancy_o;
   pkt_arr_t         dut_pkt;

   bundle_t sb[$];
   int      n_checks = 0;
   int      n_pass   = 0;

   assign dut_pkt = {dp7, dp6, dp5, dp4, dp3, dp2, dp1, dp0};

   always #5 clk = ~clk;

   decode_packet_compactor dut (
      .clk              (clk),
      .reset            (reset),
      .flush_i          (flush_i),
      .bundleValid_i    (bundleValid_i),
      .bundleVector_i   (bundleVector_i),
      .bundlePacket0_i  (in_pkt[0]),
      .bundlePacket1_i  (in_pkt[1]),
      .bundlePacket2_i  (in_pkt[2]),
      .bundlePacket3_i  (in_pkt[3]),
      .bundlePacket4_i  (in_pkt[4]),
      .bundlePacket5_i  (in_pkt[5]),
      .bundlePacket6_i  (in_pkt[6]),
      .bundlePacket7_i  (in_pkt[7]),
      .bundleReady_o    (bundleReady_o),
      .stallFetch_i     (stallFetch_i),
      .decodeReady_o    (decodeReady_o),
      .decodedVector_o  (decodedVector_o),
      .decodedPacket0_o (dp0),
      .decodedPacket1_o (dp1),
      .decodedPacket2_o (dp2),
      .decodedPacket3_o (dp3),
      .decodedPacket4_o (dp4),
      .decodedPacket5_o (dp5),
      .decodedPacket6_o (dp6),
      .decodedPacket7_o (dp7),
      .occupancy_o      (occupancy_o)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [PKT_W-1:0] rand_pkt();
      logic [191:0] r;
      for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom();
      return r[PKT_W-1:0];
   endfunction

   function automatic pkt_arr_t rand_bundle();
      pkt_arr_t p;
      for (int i = 0; i < 8; i++) p[i] = rand_pkt();
      return p;
   endfunction

   // Reference packing: walk set bits upward, then build a thermometer mask of the count.
   function automatic bundle_t compact(input logic [7:0] v, input pkt_arr_t pk);
      bundle_t b;
      int      n;
      b = '0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            b.pkt[n] = pk[i];
            n++;
         end
      end
      for (int i = 0; i < n; i++) b.vec[i] = 1'b1;
      return b;
   endfunction

   function automatic logic any_pkt_bits();
      logic r;
      r = 1'b0;
      for (int i = 0; i < 8; i++) r = r | (|dut_pkt[i]);
      return r;
   endfunction

   // One clock: drive inputs, check the presented state, update the model, advance.
   task automatic step(input logic valid, input logic [7:0] vec, input pkt_arr_t pk,
                       input logic stall, input logic flush);
      int  sz;
      logic do_pop, do_push;
      bundleValid_i  = valid;
      bundleVector_i = vec;
      in_pkt         = pk;
      stallFetch_i   = stall;
      flush_i        = flush;
      sz = sb.size();
      check("occupancy", 256'(occupancy_o), 256'(sz));
      check("bundle_ready", 256'(bundleReady_o), 256'(sz < 2));
      check("decode_ready", 256'(decodeReady_o), 256'(sz != 0));
      if (sz > 0) begin
         check("head_vec", 256'(decodedVector_o), 256'(sb[0].vec));
         for (int i = 0; i < 8; i++) check($sformatf("head_lane%0d", i), 256'(dut_pkt[i]), 256'(sb[0].pkt[i]));
      end else begin
         check("empty_vec", 256'(decodedVector_o), 256'(0));
         check("empty_pkts", 256'(any_pkt_bits()), 256'(0));
      end
      do_pop  = (sz != 0) && !stall && !flush;
      do_push = valid && (sz < 2) && (vec != 8'h00) && !flush;
      if (flush) begin
         sb.delete();
      end else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) sb.push_back(compact(vec, pk));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, '0, 1'b0, 1'b0);
   endtask

   initial begin
      pkt_arr_t p, a, b;

      reset = 1'b1;
      flush_i = 1'b0;
      bundleValid_i = 1'b0;
      bundleVector_i = '0;
      in_pkt = '0;
      stallFetch_i = 1'b0;

      #12;
      check("rst_occ", 256'(occupancy_o), 256'(0));
      check("rst_dready", 256'(decodeReady_o), 256'(0));
      check("rst_bready", 256'(bundleReady_o), 256'(1));
      check("rst_vec", 256'(decodedVector_o), 256'(0));
      check("rst_pkts", 256'(any_pkt_bits()), 256'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Sparse vector from empty: lanes 0..3 must be P0,P2,P5,P7.
      p = rand_bundle();
      step(1'b1, 8'b1010_0101, p, 1'b0, 1'b0);
      check("sparse_vec", 256'(decodedVector_o), 256'(8'b0000_1111));
      check("sparse_l0", 256'(dut_pkt[0]), 256'(p[0]));
      check("sparse_l1", 256'(dut_pkt[1]), 256'(p[2]));
      check("sparse_l2", 256'(dut_pkt[2]), 256'(p[5]));
      check("sparse_l3", 256'(dut_pkt[3]), 256'(p[7]));
      for (int i = 4; i < 8; i++) check($sformatf("sparse_zero%0d", i), 256'(dut_pkt[i]), 256'(0));
      check("sparse_dready", 256'(decodeReady_o), 256'(1));
      idle(2);

      // Stall while two bundles arrive; head must hold A, then drain A, B.
      a = rand_bundle();
      b = rand_bundle();
      step(1'b1, 8'h3C, a, 1'b1, 1'b0);
      step(1'b1, 8'h81, b, 1'b1, 1'b0);
      step(1'b0, 8'h00, '0, 1'b1, 1'b0);
      check("stall_occ", 256'(occupancy_o), 256'(2));
      check("stall_bready", 256'(bundleReady_o), 256'(0));
      check("stall_head_l0", 256'(dut_pkt[0]), 256'(a[2]));
      step(1'b1, 8'hFF, rand_bundle(), 1'b1, 1'b0);
      idle(3);

      // Streaming at occupancy 1: push and pop every cycle.
      step(1'b1, 8'h01, rand_bundle(), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'($urandom_range(1, 255)), rand_bundle(), 1'b0, 1'b0);
         check("stream_occ", 256'(occupancy_o), 256'(1));
      end
      idle(2);

      // Empty vector is discarded; full vector passes straight through.
      step(1'b1, 8'h00, rand_bundle(), 1'b0, 1'b0);
      check("zero_vec_occ", 256'(occupancy_o), 256'(0));
      p = rand_bundle();
      step(1'b1, 8'hFF, p, 1'b0, 1'b0);
      check("full_vec", 256'(decodedVector_o), 256'(8'hFF));
      check("full_l7", 256'(dut_pkt[7]), 256'(p[7]));
      idle(2);

      // Flush at occupancy 2 beats a concurrent push.
      step(1'b1, 8'h0F, rand_bundle(), 1'b1, 1'b0);
      step(1'b1, 8'hF0, rand_bundle(), 1'b1, 1'b0);
      step(1'b1, 8'h55, rand_bundle(), 1'b1, 1'b1);
      check("flush_occ", 256'(occupancy_o), 256'(0));
      check("flush_dready", 256'(decodeReady_o), 256'(0));
      idle(2);

      // Asynchronous reset between edges at occupancy 2.
      step(1'b1, 8'h12, rand_bundle(), 1'b1, 1'b0);
      step(1'b1, 8'h34, rand_bundle(), 1'b1, 1'b0);
      check("pre_rst_occ", 256'(occupancy_o), 256'(2));
      #2;
      reset = 1'b1;
      #1;
      check("arst_occ", 256'(occupancy_o), 256'(0));
      check("arst_dready", 256'(decodeReady_o), 256'(0));
      check("arst_bready", 256'(bundleReady_o), 256'(1));
      check("arst_vec", 256'(decodedVector_o), 256'(0));
      check("arst_pkts", 256'(any_pkt_bits()), 256'(0));
      sb.delete();
      bundleValid_i = 1'b0;
      flush_i = 1'b0;
      stallFetch_i = 1'b0;
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      p = rand_bundle();
      step(1'b1, 8'b1000_0000, p, 1'b0, 1'b0);
      check("post_rst_vec", 256'(decodedVector_o), 256'(8'b0000_0001));
      check("post_rst_l0", 256'(dut_pkt[0]), 256'(p[7]));
      idle(3);

      // Random traffic with stalls, sparse vectors and occasional flushes.
      for (int i = 0; i < 200; i++) begin
         step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), rand_bundle(),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
      end
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/decode_packet_compactor.md
DECODE_PACKET_COMPACTOR -- requirements
Module: decode_packet_compactor

Interface
REQ-001: Parameter LANES, default 8, SHALL set the decoded-packet slots per bundle (2*FETCH_BANDWIDTH).
REQ-002: Parameter PKT_W, default full decoded-packet width (2*SIZE_SPECIAL_REG+3+LDST_TYPES_LOG+INST_TYPES_LOG+SIZE_IMMEDIATE+1+3*SIZE_RMT_LOG+3+SIZE_OPCODE_I+2*SIZE_PC+SIZE_CTI_LOG+1), SHALL set the bits per packet.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: flush_i  input  1  synchronous control-misprediction flush.
REQ-006: bundleValid_i  input  1  upstream bundle present this cycle.
REQ-007: bundleVector_i  input  LANES  per-lane valid, arbitrary (sparse) pattern.
REQ-008: bundlePacket0_i..bundlePacket7_i  input  PKT_W each  per-lane decoded packet.
REQ-009: bundleReady_o  input-side  output  1  compactor can accept a bundle this cycle.
REQ-010: stallFetch_i  input  1  instruction-buffer backpressure; a write is ignored by the buffer in any cycle this is high.
REQ-011: decodeReady_o  output  1  head bundle presented to instruction buffer.
REQ-012: decodedVector_o  output  LANES  contiguous-from-bit-0 valid mask of presented bundle.
REQ-013: decodedPacket0_o..decodedPacket7_o  output  PKT_W each  compacted packets.
REQ-014: occupancy_o  output  2  bundles held (0..2).

Function
REQ-015: Storage SHALL be a 2-entry FIFO of compacted bundles; head entry drives all decoded*_o outputs directly from registers (no combinational path from inputs to outputs).
REQ-016: Push SHALL occur when bundleValid_i & bundleReady_o & (bundleVector_i != 0) & ~flush_i; bundles with all-zero vector SHALL be discarded without push.
REQ-017: Compaction: stored lane j SHALL hold the packet of the j-th set bit of bundleVector_i counted from bit 0 upward; stored vector SHALL equal (1<<popcount(bundleVector_i))-1; unused lanes SHALL be zero.
REQ-018: decodeReady_o SHALL equal (occupancy != 0).
REQ-019: Pop SHALL occur when decodeReady_o & ~stallFetch_i & ~flush_i; when stallFetch_i is high the head SHALL be held unchanged, outputs stable.
REQ-020: bundleReady_o SHALL equal (occupancy < 2) from registered state only; it SHALL NOT depend on stallFetch_i combinationally.
REQ-021: Latency: a bundle pushed at edge N into an empty compactor SHALL appear on outputs after edge N (visible in cycle N+1).
REQ-022: Simultaneous push and pop at occupancy 1: occupancy SHALL stay 1, pushed bundle becomes head next cycle.
REQ-023: Simultaneous push and pop at occupancy 2 cannot occur (bundleReady_o low); pop alone SHALL move the tail entry to head.
REQ-024: Pushes in order SHALL be presented in order; no bundle SHALL be duplicated or lost except by flush/reset.
REQ-025: flush_i SHALL take priority over push and pop: next cycle occupancy 0, decodeReady_o 0, vector and packets zero.
REQ-026: Occupancy SHALL never exceed 2 nor underflow below 0.

Reset
REQ-027: While reset is high, regardless of clk: occupancy_o=0, decodeReady_o=0, decodedVector_o=0, all decodedPacket*_o=0, bundleReady_o=1.
REQ-028: Reset asserted mid-stall SHALL discard both entries immediately; the first bundle after deassertion SHALL be handled as from empty.

Verification
REQ-029: Empty, push vector 8'b1010_0101 packets P0..P7 -> next cycle decodedVector_o=8'b0000_1111, lanes 0..3 = P0,P2,P5,P7, lanes 4..7 = 0, decodeReady_o=1.
REQ-030: Hold stallFetch_i=1 for 3 cycles while pushing two bundles A,B -> occupancy_o=2, bundleReady_o=0, outputs remain A; release -> A one cycle, then B, then decodeReady_o=0.
REQ-031: Occupancy 1 with stallFetch_i=0 and push each cycle of 10 bundles -> one bundle presented per cycle, occupancy_o stays 1, order preserved.
REQ-032: Push vector 8'h00 with bundleValid_i=1 -> occupancy unchanged, nothing presented; push 8'hFF -> vector_o 8'hFF, lanes unchanged in order.
REQ-033: Occupancy 2, flush_i=1 same cycle as bundleValid_i=1 -> next cycle occupancy_o=0, decodeReady_o=0, pushed bundle dropped.
REQ-034: Assert reset asynchronously between edges at occupancy 2 -> outputs zero before next edge; after release, push vector 8'b1000_0000 -> vector_o 8'b0000_0001, lane 0 = P7.
